// File: rtl/ram_flex_init.sv
// rtl/ram_flex_init.sv - tiled dual-port BRAM array with a repeating-pattern load sequencer
module ram_flex_init #(
    parameter int BITS_AU = 10,
    parameter int BITS_DU = 18,
    parameter int DEPTH = 1025,
    parameter int BITS_D = 99,
    parameter int INIT_COUNT = 71,
    parameter logic [BITS_D-1:0] INIT_ARRAY [INIT_COUNT] = '{default: '0},
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE = 0,
    localparam int BITS_A = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              init_busy,
    input  logic              ena,
    input  logic              wea,
    input  logic [BITS_A-1:0] addra,
    input  logic [BITS_D-1:0] wdataa,
    output logic [BITS_D-1:0] rdataa,
    output logic              rvalida,
    input  logic              enb,
    input  logic [BITS_A-1:0] addrb,
    output logic [BITS_D-1:0] rdatab,
    output logic              rvalidb
);
    localparam int UNIT_D = 1 << BITS_AU;
    localparam int ROWS = (DEPTH + UNIT_D - 1) / UNIT_D;
    localparam int COLS = (BITS_D + BITS_DU - 1) / BITS_DU;
    localparam int AW = ((BITS_A > BITS_AU) ? BITS_A : BITS_AU) + 1;
    localparam int RW = AW - BITS_AU;
    localparam int MW = (INIT_COUNT > 1) ? $clog2(INIT_COUNT) : 1;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state, state_n;
    logic [BITS_A-1:0] k, k_n;
    logic [MW-1:0]     m, m_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            k     <= '0;
            m     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            m     <= m_n;
        end
    end

    // m tracks k modulo INIT_COUNT so the pattern index never needs a divider
    always_comb begin
        state_n = state;
        k_n     = k;
        m_n     = m;
        case (state)
            ST_INIT: begin
                k_n = k + 1'b1;
                m_n = (m == MW'(INIT_COUNT - 1)) ? '0 : m + 1'b1;
                if (k == BITS_A'(DEPTH - 1)) begin
                    state_n = ST_READY;
                    k_n     = '0;
                    m_n     = '0;
                end
            end
            default: begin
                if (init_req) begin
                    state_n = ST_INIT;
                    k_n     = '0;
                    m_n     = '0;
                end
            end
        endcase
    end

    assign init_busy = rst || (state == ST_INIT);

    logic              ld, ua, ub, pa_en, pa_we;
    logic [BITS_A-1:0] pa_addr;
    logic [BITS_D-1:0] pa_data;

    assign ld      = (state == ST_INIT) && !rst;
    assign ua      = (state == ST_READY) && !rst && ena;
    assign ub      = (state == ST_READY) && !rst && enb;
    assign pa_en   = ld || ua;
    assign pa_we   = ld || (ua && wea);
    assign pa_addr = ld ? k : addra;
    assign pa_data = ld ? INIT_ARRAY[m] : wdataa;

    logic [AW-1:0] a_ext, b_ext;
    logic          a_in, b_in;

    assign a_ext = AW'(pa_addr);
    assign b_ext = AW'(addrb);
    assign a_in  = a_ext < AW'(DEPTH);
    assign b_in  = b_ext < AW'(DEPTH);

    logic [ROWS*BITS_D-1:0] qa_flat, qb_flat;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int LO = c * BITS_DU;
            // the last column only stores the word's remaining bits; the rest stay tied off
            localparam int CW = ((BITS_D - LO) < BITS_DU) ? (BITS_D - LO) : BITS_DU;

            logic [CW-1:0] mem [UNIT_D];
            logic [CW-1:0] qa, qb;
            logic          sel;

            assign sel = a_in && (a_ext[AW-1:BITS_AU] == RW'(r));

            always_ff @(posedge clk) begin
                if (pa_we && sel)
                    mem[a_ext[BITS_AU-1:0]] <= pa_data[LO +: CW];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    qa <= '0;
                    qb <= '0;
                end else begin
                    if (pa_en)
                        qa <= (RDW_MODE == 1 && pa_we) ? pa_data[LO +: CW]
                                                       : mem[a_ext[BITS_AU-1:0]];
                    if (ub)
                        qb <= mem[b_ext[BITS_AU-1:0]];
                end
            end

            assign qa_flat[r*BITS_D + LO +: CW] = qa;
            assign qb_flat[r*BITS_D + LO +: CW] = qb;
        end
    end

    logic              va1, vb1, za1, zb1;
    logic [RW-1:0]     ra1, rb1;
    logic [BITS_D-1:0] da1, db1;

    always_ff @(posedge clk) begin
        if (rst) begin
            va1 <= 1'b0;
            vb1 <= 1'b0;
            za1 <= 1'b0;
            zb1 <= 1'b0;
            ra1 <= '0;
            rb1 <= '0;
        end else begin
            va1 <= ua;
            vb1 <= ub;
            if (pa_en) begin
                za1 <= !a_in;
                ra1 <= a_ext[AW-1:BITS_AU];
            end
            if (ub) begin
                zb1 <= !b_in;
                rb1 <= b_ext[AW-1:BITS_AU];
            end
        end
    end

    always_comb begin
        da1 = '0;
        db1 = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!za1 && ra1 == RW'(r))
                da1 = qa_flat[r*BITS_D +: BITS_D];
            if (!zb1 && rb1 == RW'(r))
                db1 = qb_flat[r*BITS_D +: BITS_D];
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic              va2, vb2;
        logic [BITS_D-1:0] da2, db2;

        always_ff @(posedge clk) begin
            if (rst) begin
                va2 <= 1'b0;
                vb2 <= 1'b0;
                da2 <= '0;
                db2 <= '0;
            end else begin
                va2 <= va1;
                vb2 <= vb1;
                da2 <= da1;
                db2 <= db1;
            end
        end

        assign rdataa  = da2;
        assign rvalida = va2;
        assign rdatab  = db2;
        assign rvalidb = vb2;
    end else begin : g_lat1
        assign rdataa  = da1;
        assign rvalida = va1;
        assign rdatab  = db1;
        assign rvalidb = vb1;
    end
endmodule

// File: tb/tb_ram_flex_init.sv
// tb/tb_ram_flex_init.sv - randomized check of ram_flex_init against an array model
module tb_ram_flex_init;
    localparam int W = 99;
    localparam int DEPTH = 1025;
    localparam int NI = 71;
    localparam int AB = 11;

    typedef logic [W-1:0] word_t;
    typedef word_t pat_t [NI];

    function automatic pat_t gen_pat();
        pat_t p;
        for (int i = 0; i < NI; i++)
            p[i] = {3'b101, 32'(i * 7919 + 17), 32'(i) ^ 32'hdeadbeef, 32'(i * i + 1)};
        return p;
    endfunction

    localparam pat_t PAT = gen_pat();

    logic          clk, rst, init_req, ena, wea, enb;
    logic [AB-1:0] addra, addrb;
    word_t         wdataa;
    logic          busy0, rva0, rvb0, busy1, rva1, rvb1;
    word_t         rda0, rdb0, rda1, rdb1;

    ram_flex_init #(
        .BITS_AU(10), .BITS_DU(18), .DEPTH(DEPTH), .BITS_D(W), .INIT_COUNT(NI),
        .INIT_ARRAY(PAT), .RD_LATENCY(1), .RDW_MODE(1)
    ) dut0 (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy0),
        .ena(ena), .wea(wea), .addra(addra), .wdataa(wdataa),
        .rdataa(rda0), .rvalida(rva0),
        .enb(enb), .addrb(addrb), .rdatab(rdb0), .rvalidb(rvb0)
    );

    ram_flex_init #(
        .BITS_AU(10), .BITS_DU(18), .DEPTH(DEPTH), .BITS_D(W), .INIT_COUNT(NI),
        .INIT_ARRAY(PAT), .RD_LATENCY(2), .RDW_MODE(0)
    ) dut1 (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(busy1),
        .ena(ena), .wea(wea), .addra(addra), .wdataa(wdataa),
        .rdataa(rda1), .rvalida(rva1),
        .enb(enb), .addrb(addrb), .rdatab(rdb1), .rvalidb(rvb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference: word array, load progress, and per-instance result delay lines
    word_t bmem [DEPTH];
    bit    m_busy = 1'b1;
    int    m_k = 0;
    bit    e0a_v = 0, e0b_v = 0, s1a_v = 0, s1b_v = 0, e1a_v = 0, e1b_v = 0;
    word_t e0a_d = '0, e0b_d = '0, s1a_d = '0, s1b_d = '0, e1a_d = '0, e1b_d = '0;

    task automatic model_update();
        bit    va = 1'b0;
        bit    vb = 1'b0;
        word_t d_wf = '0;
        word_t d_rf = '0;
        word_t db = '0;
        if (rst) begin
            m_busy = 1'b1;
            m_k = 0;
            {e0a_v, e0b_v, s1a_v, s1b_v, e1a_v, e1b_v} = '0;
            e0a_d = '0; e0b_d = '0; s1a_d = '0; s1b_d = '0; e1a_d = '0; e1b_d = '0;
            return;
        end
        if (m_busy) begin
            bmem[m_k] = PAT[m_k % NI];
            if (m_k == DEPTH - 1) m_busy = 1'b0;
            else m_k++;
        end else begin
            if (enb) begin
                vb = 1'b1;
                if (int'(addrb) < DEPTH) db = bmem[addrb];
            end
            if (ena) begin
                va = 1'b1;
                if (int'(addra) < DEPTH) begin
                    d_rf = bmem[addra];
                    d_wf = wea ? wdataa : bmem[addra];
                    if (wea) bmem[addra] = wdataa;
                end
            end
            if (init_req) begin
                m_busy = 1'b1;
                m_k = 0;
            end
        end
        e1a_v = s1a_v; e1a_d = s1a_d; s1a_v = va; s1a_d = d_rf;
        e1b_v = s1b_v; e1b_d = s1b_d; s1b_v = vb; s1b_d = db;
        e0a_v = va; if (va) e0a_d = d_wf;
        e0b_v = vb; if (vb) e0b_d = db;
    endtask

    task automatic compare();
        check("busy0", W'(busy0), W'(m_busy));
        check("busy1", W'(busy1), W'(m_busy));
        check("rvalida0", W'(rva0), W'(e0a_v));
        check("rvalidb0", W'(rvb0), W'(e0b_v));
        check("rvalida1", W'(rva1), W'(e1a_v));
        check("rvalidb1", W'(rvb1), W'(e1b_v));
        if (rst) begin
            check("rdataa0_rst", rda0, '0);
            check("rdatab0_rst", rdb0, '0);
            check("rdataa1_rst", rda1, '0);
            check("rdatab1_rst", rdb1, '0);
        end
        if (e0a_v) check("rdataa0", rda0, e0a_d);
        if (e0b_v) check("rdatab0", rdb0, e0b_d);
        if (e1a_v) check("rdataa1", rda1, e1a_d);
        if (e1b_v) check("rdatab1", rdb1, e1b_d);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    function automatic word_t rword();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic drive(input bit ea, input bit wa, input int aa, input word_t da,
                         input bit eb, input int ab);
        ena = ea; wea = wa; addra = AB'(aa); wdataa = da; enb = eb; addrb = AB'(ab);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, 1'b0, 0);
        init_req = 1'b0;
    endtask

    task automatic rand_req(input int init_odds);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1031)),
              rword(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1031)));
        init_req = ($urandom_range(0, init_odds - 1) == 0);
    endtask

    task automatic count_load(input string tag);
        int n = 0;
        while (busy0 && n < 3000) begin
            n++;
            rand_req(16);
            step();
        end
        idle();
        check(tag, W'(n), W'(DEPTH));
    endtask

    initial begin
        word_t x;
        rst = 1'b1;
        idle();
        repeat (3) step();

        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rand_req(16);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_load("load_len");

        drive(1'b0, 1'b0, 0, '0, 1'b1, 71);
        step();
        check("b71_valid", W'(rvb0), W'(1));
        check("b71", rdb0, PAT[0]);
        drive(1'b0, 1'b0, 0, '0, 1'b1, 1024);
        step();
        check("b1024", rdb0, PAT[30]);
        drive(1'b0, 1'b0, 0, '0, 1'b1, 10);
        step();
        check("b10_after_init", rdb0, PAT[10]);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 0, '0, 1'b1, i);
            step();
        end

        drive(1'b1, 1'b1, 5, W'(1), 1'b0, 0);
        step();
        drive(1'b1, 1'b0, 5, '0, 1'b0, 0);
        step();
        idle();
        step();
        check("a5_lat2_valid", W'(rva1), W'(1));
        check("a5_lat2", rda1, W'(1));

        x = rword();
        drive(1'b1, 1'b1, 7, x, 1'b1, 7);
        step();
        check("rdw_a_write_first", rda0, x);
        check("rdw_b0_old", rdb0, PAT[7]);
        idle();
        step();
        check("rdw_a_read_first", rda1, PAT[7]);
        check("rdw_b1_old", rdb1, PAT[7]);

        drive(1'b1, 1'b1, 1030, rword(), 1'b0, 0);
        step();
        check("oor_valid", W'(rva0), W'(1));
        check("oor_zero", rda0, '0);
        idle();

        for (int i = 0; i < 3000; i++) begin
            rand_req(600);
            step();
        end
        idle();
        for (int i = 0; i < 1200 && busy0; i++) step();
        check("ready_before_reinit", W'(busy0), W'(0));

        drive(1'b1, 1'b1, 3, rword(), 1'b0, 0);
        step();
        idle();
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        count_load("reinit_len");
        drive(1'b1, 1'b0, 3, '0, 1'b0, 0);
        step();
        check("a3_reinit", rda0, PAT[3]);

        for (int i = 0; i < 1032; i++) begin
            drive(1'b1, 1'b0, i, '0, 1'b1, 1031 - i);
            step();
        end
        idle();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_flex_init.md
# ram_flex_init

Dual-port, single-clock RAM built from a tiled grid of FPGA BRAM primitives sized by `BITS_AU`/`BITS_DU`, generalising the flex ROM to arbitrary `DEPTH` × `BITS_D`. Port A reads and writes; port B is read-only. A built-in sequencer loads the contents from a repeating parameter pattern after every reset or on request, so the block can also stand in for ROM_flex. Read latency and read-during-write mode are parameters, and every read result carries a valid strobe.

## Interface
- `BITS_AU`, 10: address bits of one BRAM primitive.
- `BITS_DU`, 18: data bits of one BRAM primitive.
- `DEPTH`, 1025: number of words, ≥1.
- `BITS_D`, 99: word width.
- `INIT_COUNT`, 71: number of entries in `INIT_ARRAY`, ≥1.
- `INIT_ARRAY`, all zero: `[BITS_D-1:0]` array of `INIT_COUNT` entries; word k is loaded with `INIT_ARRAY[k % INIT_COUNT]`.
- `RD_LATENCY`, 1: read latency in cycles, 1 or 2 (2 adds an output register).
- `RDW_MODE`, 0: port A read-during-write behaviour; 0 = READ_FIRST, 1 = WRITE_FIRST.
- `BITS_A`: derived localparam = log2(DEPTH), same definition as the codebase's log2 function.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `init_req` in 1: single-cycle pulse that restarts the load sequence.
- `init_busy` out 1: high while the load sequence runs.
- `ena` in 1: port A request.
- `wea` in 1: port A write enable, qualified by `ena`.
- `addra` in BITS_A: port A address.
- `wdataa` in BITS_D: port A write data.
- `rdataa` out BITS_D: port A read data.
- `rvalida` out 1: `rdataa` valid strobe.
- `enb` in 1: port B read request.
- `addrb` in BITS_A: port B address.
- `rdatab` out BITS_D: port B read data.
- `rvalidb` out 1: `rdatab` valid strobe.

## Operation
- Tiling: the array is ceil(DEPTH/2^BITS_AU) rows × ceil(BITS_D/BITS_DU) columns of primitives.
  - The upper address bits select the row, through a registered row select aligned to the read latency.
  - Unused top bits of the last column are tied to 0.
- FSM states:
  - INIT: counter `k` steps 0…DEPTH-1. One write per cycle of the pattern word to address k through the port A datapath. A second counter `m` wraps at INIT_COUNT; no divider is used.
  - READY: user traffic is accepted.
- FSM transitions:
  - INIT → READY after the write of address DEPTH-1.
  - READY → INIT on `init_req`.
  - Any state → INIT with k = m = 0 while `rst` is high.
- Requests while `init_busy` = 1:
  - User requests on both ports are dropped: no write and no rvalid.
  - `init_req` is ignored.
- Port A request with `wea` = 1:
  - Writes the word.
  - Also produces a read: `rvalida` pulses, and `rdataa` is the old word (READ_FIRST) or `wdataa` (WRITE_FIRST).
- Port A request with `wea` = 0: read only.
- Port B:
  - Reads only.
  - When it reads the same address port A writes in the same cycle, it always returns the old word.
- Address ≥ DEPTH:
  - A write is discarded.
  - A read returns all zeros with its rvalid still asserted.

## Timing
- Reset values:
  - `rdataa` = `rdatab` = 0.
  - `rvalida` = `rvalidb` = 0.
  - `init_busy` = 1, held for the whole time `rst` is high.
- Edge 0 is defined as the first rising edge with `rst` = 0.
  - Address k is loaded at edge k.
  - `init_busy` falls after edge DEPTH-1.
  - The first user request is accepted at edge DEPTH.
- `init_req` sampled high at edge t in READY:
  - `init_busy` rises after edge t.
  - Address 0 is rewritten at edge t+1.
  - A user request sampled at edge t is still served.
- Read latency: for a request accepted at edge t, rdata and rvalid are valid after edge t+RD_LATENCY-1 and sampled at edge t+RD_LATENCY. rvalid is high for exactly one cycle per request.
- With back-to-back requests, one result is returned per cycle, with no bubbles.
- `rst` asserted mid-init or mid-read:
  - In-flight rvalid pipeline stages are cleared.
  - Loading restarts at address 0.
- Memory contents are not cleared by `rst`; they are overwritten by the load sequence.

## Test plan
- Post-reset load (DEPTH = 1025, INIT_COUNT = 71):
  - Stimulus: deassert `rst`, then run port B over addresses 0…1024.
  - Required: `init_busy` stays high for exactly 1025 cycles; address 71 reads `INIT_ARRAY[0]`; address 1024 reads `INIT_ARRAY[30]`.
- Write then read, RD_LATENCY = 2:
  - Stimulus: port A writes `99'h1` to address 5, then port A reads address 5 on the next cycle.
  - Required: `rdataa` = 1 with `rvalida` high two cycles after the read edge.
- Read-during-write:
  - Stimulus: in one cycle, port A writes X to address 7 and port B reads address 7.
  - Required: B returns the pattern value. A returns the pattern value when RDW_MODE = 0, or X when RDW_MODE = 1.
- Requests during init:
  - Stimulus: issue a write and reads while `init_busy` = 1.
  - Required: `rvalida` and `rvalidb` stay 0, and the location still holds the pattern value after init completes.
- Reset mid-init and re-init:
  - Stimulus: pulse `rst` at cycle 500 of the load, then later pulse `init_req` after overwriting address 3 through port A.
  - Required: the full 1025-cycle load reruns after the reset; after the `init_req` load, address 3 again reads `INIT_ARRAY[3]`.
- Out of range:
  - Stimulus: port A write and read at address 1030.
  - Required: no word changes, and the read returns 0 with `rvalida` = 1.
